pe_comp_ctrl: RTL and testbench

- Parametrised next-generation PE computation controller.
- Sequences per-layer weight computation for one PE: pops broadcast input activations from the PE activation queue and sweeps each one across the PE's output activations.
- Generalised over index/data widths and lane count LANES, so one issue covers up to LANES output activations.
- Adds datapath backpressure (comp_ready), partial-group lane masking and an all-layers-done pulse.

---
 rtl/pe_comp_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pe_comp_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_comp_ctrl.sv
// PE computation controller: sweeps queued input activations across local output activations.
// Optional build macro PE_COMP_ZERO_SKIP_EN drops zero-valued queue heads without issuing.
module pe_comp_ctrl #(
    parameter int PE_IDX_W   = 6,
    parameter int ACT_NO_W   = 6,
    parameter int LAYER_NO_W = 4,
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 12,
    parameter int LANES      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PE_IDX_W-1:0]          pe_idx,
    input  logic                         pe_start_calc,
    output logic                         pe_start_broadcast,
    input  logic                         fin_broadcast,
    output logic                         fin_comp,
    input  logic                         layer_done,
    output logic                         all_done,
    input  logic [LAYER_NO_W-1:0]        layer_no,
    input  logic [ACT_NO_W-1:0]          out_act_no,
    output logic [LAYER_NO_W-1:0]        layer_idx,
    output logic                         act_regfile_dir,
    input  logic                         queue_empty,
    input  logic [IDX_W+DATA_W-1:0]      act_out,
    output logic                         pop_act,
    output logic                         out_act_clear,
    input  logic                         comp_ready,
    output logic                         comp_en,
    output logic [LANES-1:0]             comp_lane_mask,
    output logic [IDX_W-1:0]             in_act_idx,
    output logic [DATA_W-1:0]            in_act_value,
    output logic [ACT_NO_W-1:0]          out_act_addr,
    output logic [ACT_NO_W+PE_IDX_W-1:0] out_act_idx
);

    // Wide enough that grp + LANES never wraps for LANES up to 16.
    localparam int CW = ACT_NO_W + 5;

    typedef enum logic [1:0] {
        IDLE,
        PRE_BC,
        POST_BC,
        LAYER_SYNC
    } state_t;

    state_t                state_q;
    logic [ACT_NO_W-1:0]   grp_q;
    logic [ACT_NO_W-1:0]   grp_d;
    logic [LAYER_NO_W-1:0] layer_q;
    logic                  dir_q;
    logic                  sb_q;
    logic                  clr_q;
    logic                  done_q;

    logic                  busy;
    logic                  head_zero;
    logic                  drain;
    logic                  issue;
    logic                  last_grp;
    logic [CW-1:0]         grp_w;
    logic [CW-1:0]         n_w;
    logic [LAYER_NO_W-1:0] last_layer;

    assign busy = (state_q == PRE_BC) || (state_q == POST_BC);

`ifdef PE_COMP_ZERO_SKIP_EN
    assign head_zero = (act_out[DATA_W-1:0] == '0);
`else
    assign head_zero = 1'b0;
`endif

    // Heads that cannot be issued are consumed without waiting for the datapath.
    assign drain = busy && !queue_empty
                   && ((out_act_no == '0) || head_zero);
    assign issue = busy && !queue_empty && comp_ready && !drain;

    assign grp_w    = CW'(grp_q);
    assign n_w      = CW'(out_act_no);
    assign last_grp = (grp_w + CW'(LANES)) >= n_w;

    assign last_layer = (layer_no == '0) ? '0 : layer_no - 1'b1;

    always_comb begin
        comp_lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            comp_lane_mask[i] = issue && ((grp_w + CW'(i)) < n_w);
        end
    end

    always_comb begin
        grp_d = grp_q;
        if (issue) begin
            grp_d = last_grp ? '0 : grp_q + ACT_NO_W'(LANES);
        end
    end

    assign comp_en      = issue;
    assign pop_act      = drain || (issue && last_grp);
    assign fin_comp     = (state_q == POST_BC) && queue_empty;
    assign out_act_addr = issue ? grp_q : '0;
    assign out_act_idx  = issue ? {grp_q, pe_idx} : '0;
    assign in_act_idx   = issue ? act_out[IDX_W+DATA_W-1:DATA_W] : '0;
    assign in_act_value = issue ? act_out[DATA_W-1:0] : '0;

    assign pe_start_broadcast = sb_q;
    assign out_act_clear      = clr_q;
    assign all_done           = done_q;
    assign layer_idx          = layer_q;
    assign act_regfile_dir    = dir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            layer_q <= '0;
            dir_q   <= 1'b0;
            sb_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sb_q   <= 1'b0;
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            grp_q  <= grp_d;
            unique case (state_q)
                IDLE: begin
                    if (pe_start_calc) begin
                        state_q <= PRE_BC;
                        layer_q <= '0;
                        grp_q   <= '0;
                        sb_q    <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                PRE_BC: begin
                    if (fin_broadcast) begin
                        state_q <= POST_BC;
                    end
                end
                POST_BC: begin
                    if (queue_empty) begin
                        state_q <= LAYER_SYNC;
                    end
                end
                LAYER_SYNC: begin
                    if (layer_done) begin
                        if (layer_q == last_layer) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PRE_BC;
                            layer_q <= layer_q + 1'b1;
                            dir_q   <= !dir_q;
                            grp_q   <= '0;
                            sb_q    <= 1'b1;
                            clr_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_comp_ctrl.sv
// Bench for pe_comp_ctrl: directed scenarios plus random traffic against a queue-level model.
// Define PE_COMP_ZERO_SKIP_EN for both files to cover the zero-skip build.
module tb_pe_comp_ctrl;

    localparam int PW = 6;
    localparam int AW = 6;
    localparam int LW = 4;
    localparam int DW = 16;
    localparam int IW = 12;
    localparam int LN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [PW-1:0]     pe_idx;
    logic              pe_start_calc;
    logic              pe_start_broadcast;
    logic              fin_broadcast;
    logic              fin_comp;
    logic              layer_done;
    logic              all_done;
    logic [LW-1:0]     layer_no;
    logic [AW-1:0]     out_act_no;
    logic [LW-1:0]     layer_idx;
    logic              act_regfile_dir;
    logic              queue_empty;
    logic [IW+DW-1:0]  act_out;
    logic              pop_act;
    logic              out_act_clear;
    logic              comp_ready;
    logic              comp_en;
    logic [LN-1:0]     comp_lane_mask;
    logic [IW-1:0]     in_act_idx;
    logic [DW-1:0]     in_act_value;
    logic [AW-1:0]     out_act_addr;
    logic [AW+PW-1:0]  out_act_idx;

    pe_comp_ctrl #(
        .PE_IDX_W(PW), .ACT_NO_W(AW), .LAYER_NO_W(LW),
        .DATA_W(DW), .IDX_W(IW), .LANES(LN)
    ) dut (
        .clk(clk), .rst(rst), .pe_idx(pe_idx),
        .pe_start_calc(pe_start_calc),
        .pe_start_broadcast(pe_start_broadcast),
        .fin_broadcast(fin_broadcast), .fin_comp(fin_comp),
        .layer_done(layer_done), .all_done(all_done),
        .layer_no(layer_no), .out_act_no(out_act_no),
        .layer_idx(layer_idx), .act_regfile_dir(act_regfile_dir),
        .queue_empty(queue_empty), .act_out(act_out),
        .pop_act(pop_act), .out_act_clear(out_act_clear),
        .comp_ready(comp_ready), .comp_en(comp_en),
        .comp_lane_mask(comp_lane_mask),
        .in_act_idx(in_act_idx), .in_act_value(in_act_value),
        .out_act_addr(out_act_addr), .out_act_idx(out_act_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: activation queue, phase of the layer, and issues done on the head.
    logic [IW+DW-1:0] q[$];
    int     m_phase;  // 0 idle, 1 broadcasting, 2 draining, 3 waiting sync
    int     m_k;
    int     m_layer;
    bit     m_dir, m_sb, m_clr, m_done;

    int     cap_addr[$];
    int     cap_mask[$];
    int     cap_idx[$];
    int     cnt_pop, cnt_en;
    bit     last_fin, last_sb, last_done, last_any;
    int     last_layer, last_dir;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr_cap();
        cap_addr.delete();
        cap_mask.delete();
        cap_idx.delete();
        cnt_pop = 0;
        cnt_en  = 0;
    endtask

    task automatic cyc();
        bit   act, ne, zs, e_en, e_pop, e_fin;
        int   addr, n, lastl;
        logic [LN-1:0] e_mask;
        logic [IW+DW-1:0] h;
        queue_empty = (q.size() == 0);
        act_out     = (q.size() != 0) ? q[0] : '0;
        #1;
        if (rst) begin
            m_phase = 0; m_k = 0; m_layer = 0;
            m_dir = 0; m_sb = 0; m_clr = 0; m_done = 0;
        end
        n      = int'(out_act_no);
        act    = (m_phase == 1) || (m_phase == 2);
        ne     = (q.size() != 0);
        h      = ne ? q[0] : '0;
        zs     = 1'b0;
`ifdef PE_COMP_ZERO_SKIP_EN
        zs     = ne && (h[DW-1:0] == 0);
`endif
        e_en   = 0;
        e_pop  = 0;
        e_mask = '0;
        addr   = 0;
        if (act && ne) begin
            if (n == 0 || zs) begin
                e_pop = 1;
            end else if (comp_ready) begin
                e_en  = 1;
                addr  = m_k * LN;
                for (int i = 0; i < LN; i++) e_mask[i] = (addr + i < n);
                e_pop = (addr + LN >= n);
            end
        end
        e_fin = (m_phase == 2) && !ne;

        chk("comp_en", comp_en, e_en);
        chk("pop_act", pop_act, e_pop);
        chk("fin_comp", fin_comp, e_fin);
        chk("lane_mask", comp_lane_mask, e_mask);
        chk("out_act_addr", out_act_addr, e_en ? addr : 0);
        chk("out_act_idx", out_act_idx,
            e_en ? (addr << PW) | int'(pe_idx) : 0);
        chk("in_act_idx", in_act_idx, e_en ? h[IW+DW-1:DW] : '0);
        chk("in_act_value", in_act_value, e_en ? h[DW-1:0] : '0);
        chk("start_bc", pe_start_broadcast, m_sb);
        chk("act_clear", out_act_clear, m_clr);
        chk("all_done", all_done, m_done);
        chk("layer_idx", layer_idx, m_layer);
        chk("regfile_dir", act_regfile_dir, m_dir);

        if (comp_en) begin
            cap_addr.push_back(int'(out_act_addr));
            cap_mask.push_back(int'(comp_lane_mask));
            cap_idx.push_back(int'(out_act_idx));
            cnt_en++;
        end
        if (pop_act) cnt_pop++;
        last_fin   = fin_comp;
        last_sb    = pe_start_broadcast;
        last_done  = all_done;
        last_layer = int'(layer_idx);
        last_dir   = int'(act_regfile_dir);
        last_any   = comp_en | pop_act | fin_comp | (|comp_lane_mask)
                   | (|out_act_addr) | (|out_act_idx) | (|in_act_idx)
                   | (|in_act_value) | pe_start_broadcast | out_act_clear
                   | all_done | (|layer_idx) | act_regfile_dir;

        if (!rst) begin
            if (e_pop) void'(q.pop_front());
            if (e_en) m_k = e_pop ? 0 : m_k + 1;
            m_sb = 0; m_clr = 0; m_done = 0;
            lastl = (layer_no == 0) ? 0 : int'(layer_no) - 1;
            case (m_phase)
                0: if (pe_start_calc) begin
                    m_phase = 1; m_layer = 0; m_k = 0;
                    m_sb = 1; m_clr = 1;
                end
                1: if (fin_broadcast) m_phase = 2;
                2: if (e_fin) m_phase = 3;
                default: if (layer_done) begin
                    if (m_layer == lastl) begin
                        m_phase = 0; m_done = 1;
                    end else begin
                        m_phase = 1; m_layer++; m_dir = !m_dir;
                        m_k = 0; m_sb = 1; m_clr = 1;
                    end
                end
            endcase
        end
        @(negedge clk);
    endtask

    function automatic logic [IW+DW-1:0] ent(int idx, int val);
        return {IW'(idx), DW'(val)};
    endfunction

    initial begin
        rst = 1; pe_idx = 5; pe_start_calc = 0; fin_broadcast = 0;
        layer_done = 0; layer_no = 2; out_act_no = 10; comp_ready = 1;
        queue_empty = 1; act_out = '0;
        @(negedge clk);
        cyc();
        cyc();
        chk("reset_quiet", last_any, 0);
        rst = 0;
        cyc();

        // Three groups over ten outputs
        pe_start_calc = 1;
        cyc();
        pe_start_calc = 0;
        clr_cap();
        q.push_back(ent(12'h123, 16'h0042));
        repeat (3) cyc();
        chk("t2_issues", cap_addr.size(), 3);
        if (cap_addr.size() == 3) begin
            chk("t2_addr0", cap_addr[0], 0);
            chk("t2_addr1", cap_addr[1], 4);
            chk("t2_addr2", cap_addr[2], 8);
            chk("t2_mask0", cap_mask[0], 4'b1111);
            chk("t2_mask2", cap_mask[2], 4'b0011);
            chk("t2_idx2", cap_idx[2], 12'h205);
        end
        chk("t2_pops", cnt_pop, 1);

        // Backpressure: ready 1,0,0,1
        out_act_no = 8;
        clr_cap();
        q.push_back(ent(12'h7, 16'h1234));
        comp_ready = 1; cyc();
        comp_ready = 0; cyc(); cyc();
        comp_ready = 1; cyc();
        chk("t3_issues", cap_addr.size(), 2);
        if (cap_addr.size() == 2) chk("t3_addr1", cap_addr[1], 4);
        chk("t3_pops", cnt_pop, 1);

        // Two-layer sequencing
        fin_broadcast = 1; cyc();
        fin_broadcast = 0; cyc();
        chk("t4_fin", last_fin, 1);
        layer_done = 1; cyc();
        layer_done = 0; cyc();
        chk("t4_layer", last_layer, 1);
        chk("t4_dir", last_dir, 1);
        chk("t4_sb", last_sb, 1);
        fin_broadcast = 1; cyc();
        fin_broadcast = 0; cyc();
        layer_done = 1; cyc();
        layer_done = 0; cyc();
        chk("t4_all_done", last_done, 1);

        // No local outputs: queue drains without issues
        pe_start_calc = 1; cyc();
        pe_start_calc = 0;
        out_act_no = 0;
        clr_cap();
        repeat (3) q.push_back(ent($urandom, $urandom));
        repeat (3) cyc();
        chk("t5_pops", cnt_pop, 3);
        chk("t5_no_issue", cnt_en, 0);

`ifdef PE_COMP_ZERO_SKIP_EN
        out_act_no = 10;
        clr_cap();
        q.push_back(ent(1, 0));
        q.push_back(ent(2, 7));
        repeat (4) cyc();
        chk("zs_pops", cnt_pop, 2);
        chk("zs_issues", cnt_en, 3);
`endif

        // Reset during drain phase
        fin_broadcast = 1; cyc();
        fin_broadcast = 0;
        out_act_no = 8; comp_ready = 0;
        q.push_back(ent(3, 9));
        cyc(); cyc();
        rst = 1; cyc();
        chk("t6_reset_quiet", last_any, 0);
        q.delete();
        rst = 0; comp_ready = 1; cyc();
        pe_start_calc = 1; cyc();
        pe_start_calc = 0; cyc();
        chk("t6_layer", last_layer, 0);
        chk("t6_sb", last_sb, 1);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) begin
                out_act_no = AW'($urandom_range(0, 20));
                layer_no   = LW'($urandom_range(0, 3));
                pe_idx     = PW'($urandom);
            end
            pe_start_calc = ($urandom % 8 == 0);
            fin_broadcast = ($urandom % 6 == 0);
            layer_done    = ($urandom % 4 == 0);
            comp_ready    = ($urandom % 4 != 0);
            if (q.size() < 3 && $urandom % 3 == 0)
                q.push_back(ent($urandom,
                    ($urandom % 4 == 0) ? 0 : $urandom));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
